// File: rtl/aes_round_ctrl.sv
// Column/round sequencer for the 32-bit-per-cycle AES datapath.
// Optional abort port pair enabled by AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl #(
    parameter int NR    = 10,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             key_ready,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             busy,
    output logic             done,
    output logic [3:0]       round,
    output logic [2:0]       col_sel,
    output logic             key_req,
    output logic [IDX_W-1:0] key_word_idx,
    output logic             load_state,
    output logic             mix_bypass,
    output logic             xor_en,
    output logic             state_wb
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XOR,
        WB,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t     state;
    logic [3:0] round_q;
    logic [1:0] col_q;
    logic       abort_hit;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_hit = abort &&
                       (state == REQ || state == XOR || state == WB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aborted <= 1'b0;
        end else begin
            aborted <= abort_hit;
        end
    end
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            round_q <= '0;
            col_q   <= '0;
        end else if (abort_hit) begin
            state   <= IDLE;
            round_q <= '0;
            col_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= REQ;
                        round_q <= '0;
                        col_q   <= '0;
                    end
                end
                REQ: begin
                    if (key_ready) begin
                        state <= XOR;
                    end
                end
                XOR: begin
                    if (col_q == 2'd3) begin
                        state <= WB;
                    end else begin
                        col_q <= col_q + 2'd1;
                        state <= REQ;
                    end
                end
                WB: begin
                    if (round_q == LAST) begin
                        state <= DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                        col_q   <= '0;
                        state   <= REQ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A 2-bit column counter keeps col_sel out of the 4..7 clear codes.
    assign col_sel      = {1'b0, col_q};
    assign round        = round_q;
    assign key_word_idx = IDX_W'({round_q, 2'b00}) + IDX_W'(col_q);
    assign busy         = (state != IDLE);
    assign key_req      = (state == REQ);
    assign xor_en       = (state == XOR);
    assign state_wb     = (state == WB);
    assign done         = (state == DONE);
    assign load_state   = (round_q == 4'd0);
    assign mix_bypass   = (round_q == LAST);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl (NR = 10).
module tb_aes_round_ctrl;

    localparam int NR = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       key_ready;
    logic       busy;
    logic       done;
    logic [3:0] round;
    logic [2:0] col_sel;
    logic       key_req;
    logic [5:0] key_word_idx;
    logic       load_state;
    logic       mix_bypass;
    logic       xor_en;
    logic       state_wb;
`ifdef AES_ROUND_CTRL_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    aes_round_ctrl #(.NR(NR), .IDX_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .key_ready    (key_ready),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort        (abort),
        .aborted      (aborted),
`endif
        .busy         (busy),
        .done         (done),
        .round        (round),
        .col_sel      (col_sel),
        .key_req      (key_req),
        .key_word_idx (key_word_idx),
        .load_state   (load_state),
        .mix_bypass   (mix_bypass),
        .xor_en       (xor_en),
        .state_wb     (state_wb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int xc, wc, dc, done_cyc, stall_n;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_round"}, 32'(round), 0);
        chk({tag, "_col"}, 32'(col_sel), 0);
        chk({tag, "_idx"}, 32'(key_word_idx), 0);
        chk({tag, "_req"}, 32'(key_req), 0);
        chk({tag, "_xor"}, 32'(xor_en), 0);
        chk({tag, "_wb"}, 32'(state_wb), 0);
        chk({tag, "_load"}, 32'(load_state), 1);
    endtask

    task automatic quiet_run(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done || state_wb || busy) bad++;
        end
        chk(tag, 32'(bad), 0);
    endtask

    task automatic reset_mid();
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        @(posedge clk);
        #1 reset = 1'b0;
        quiet_run("midrst_quiet", 20);
    endtask

    task automatic run_block(input bit stall, input bit restart,
                             input int rst_rnd);
        bit hit = 1'b0;
        xc = 0; wc = 0; dc = 0; done_cyc = -1; stall_n = 0;
        @(posedge clk);
        #1 start = 1'b1;
        key_ready = 1'b1;
        for (int cyc = 1; cyc <= 160 && !hit; cyc++) begin
            @(posedge clk);
            #1 start = restart && (cyc == 30);
            key_ready = 1'b1;
            if (stall && key_req && key_word_idx == 6'd17 && stall_n < 5) begin
                key_ready = 1'b0;
                stall_n++;
            end
            @(negedge clk);
            if (!key_ready) begin
                chk("stall_req", 32'(key_req), 1);
                chk("stall_idx", 32'(key_word_idx), 17);
                chk("stall_xor", 32'(xor_en), 0);
            end
            if (xor_en) begin
                chk("col", 32'(col_sel), 32'(xc % 4));
                chk("kidx", 32'(key_word_idx), 32'(xc));
                chk("xround", 32'(round), 32'(xc / 4));
                chk("load", 32'(load_state), 32'(xc < 4));
                chk("bypass", 32'(mix_bypass), 32'(xc >= 40));
                xc++;
                if (rst_rnd >= 0 && int'(round) == rst_rnd) begin
                    reset_mid();
                    hit = 1'b1;
                end
            end
            if (!hit && state_wb) begin
                chk("wbround", 32'(round), 32'(wc));
                wc++;
            end
            if (!hit && done) begin
                dc++;
                done_cyc = cyc;
                chk("done_round", 32'(round), NR);
                chk("done_col", 32'(col_sel), 3);
            end
            if (done_cyc >= 0 && cyc > done_cyc) break;
        end
    endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
    task automatic abort_test();
        bit found = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        key_ready = 1'b1;
        for (int cyc = 1; cyc <= 60 && !found; cyc++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            if (xor_en && round == 4'd3 && col_sel == 3'd3) found = 1'b1;
        end
        chk("ab_found", 32'(found), 1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("ab_wb", 32'(state_wb), 0);
        chk("ab_pulse", 32'(aborted), 1);
        chk("ab_round", 32'(round), 0);
        chk("ab_col", 32'(col_sel), 0);
        chk("ab_busy", 32'(busy), 0);
        @(negedge clk);
        chk("ab_pulse_end", 32'(aborted), 0);
        quiet_run("ab_quiet", 20);
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        key_ready = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_idx", 32'(key_word_idx), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_req", 32'(key_req), 0);
        end

        run_block(1'b0, 1'b0, -1);
        chk("nom_done_cyc", 32'(done_cyc), 100);
        chk("nom_dones", 32'(dc), 1);
        chk("nom_xors", 32'(xc), 44);
        chk("nom_wbs", 32'(wc), 11);

        run_block(1'b1, 1'b0, -1);
        chk("stall_done_cyc", 32'(done_cyc), 105);
        chk("stall_cycles", 32'(stall_n), 5);
        chk("stall_xors", 32'(xc), 44);

        run_block(1'b0, 1'b1, -1);
        chk("busy_start_done_cyc", 32'(done_cyc), 100);
        chk("busy_start_dones", 32'(dc), 1);
        chk("busy_start_wbs", 32'(wc), 11);

        run_block(1'b0, 1'b0, 6);
        chk("rst_dones", 32'(dc), 0);
        chk("rst_xors", 32'(xc), 25);
        chk("rst_wbs", 32'(wc), 6);

        run_block(1'b0, 1'b0, -1);
        chk("clean_done_cyc", 32'(done_cyc), 100);
        chk("clean_dones", 32'(dc), 1);
        chk("clean_xors", 32'(xc), 44);

`ifdef AES_ROUND_CTRL_ABORT_EN
        abort_test();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencer for the compact 32-bit-per-cycle AES datapath.
- Steps the column index of the column-wise AddRoundKey stage through columns 0..3 for every round, 0..NR.
- Fetches one round-key word per column from the key schedule using a req/ready handshake.
- Signals state write-back after each round, final-round MixColumns bypass, and completion.

Parameters:
- NR, 10, number of AES rounds; legal values 10, 12, 14.
- IDX_W, 6, width of key_word_idx; must hold 4*NR+3.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin one block; sampled only in IDLE.
- key_ready  in  1  key schedule presents the requested word this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- round  out  4  current round number, 0..NR.
- col_sel  out  3  column index to the AddRoundKey stage; values 0..3 only.
- key_req  out  1  request for key word key_word_idx.
- key_word_idx  out  IDX_W  equals 4*round + col_sel.
- load_state  out  1  high during round 0; column source is plaintext, not the state register.
- mix_bypass  out  1  high while round == NR; skips MixColumns.
- xor_en  out  1  AddRoundKey capture strobe for column col_sel.
- state_wb  out  1  one-cycle strobe; the 128-bit AddRoundKey result is written to the state register.

Behaviour:
- Reset values (asynchronous):
  - FSM = IDLE; round = 0; col_sel = 0; key_word_idx = 0.
  - busy, done, key_req, xor_en and state_wb = 0.
  - load_state = 1, because round = 0.
- All outputs are registered, or decoded from registered state and counters only. No combinational path from any input to any output.
- States: IDLE, REQ, XOR, WB, DONE.
- IDLE:
  - start = 1 moves to REQ; round and col_sel are reset to 0.
  - start is ignored in every other state.
- REQ:
  - key_req = 1, held level until key_ready is seen.
  - key_ready = 1 moves to XOR. Otherwise stay in REQ; no timeout.
- XOR:
  - xor_en = 1 for exactly one cycle. The key word for key_word_idx must still be driven in this cycle.
  - key_ready is ignored.
  - If col_sel < 3: col_sel increments and the FSM returns to REQ.
  - If col_sel = 3: go to WB.
- WB:
  - state_wb = 1.
  - If round = NR: go to DONE.
  - Otherwise: round increments, col_sel wraps to 0, go to REQ.
- DONE:
  - done = 1 for one cycle, then IDLE.
  - round and col_sel hold their last values, NR and 3, until the next start.
- col_sel holds its value outside XOR, and never takes values 4..7, which would clear the capture register.
- Timing with key_ready tied high:
  - 2 cycles per column; 9 cycles per round; (NR+1)*9 cycles from REQ entry to the end of the last WB.
  - For NR = 10, done is high in cycle 100, counting the cycle in which start is sampled as cycle 0.
- Reset asserted mid-operation aborts immediately. No done and no state_wb is issued afterwards.

Optional Feature:
- Macro: AES_ROUND_CTRL_ABORT_EN.
- When defined:
  - Adds input abort (1 bit) and output aborted (1 bit).
  - abort = 1 in REQ, XOR or WB moves to IDLE on the next edge. That edge produces no xor_en, state_wb or done.
  - aborted pulses high for one cycle in IDLE; round and col_sel are cleared to 0.
  - abort in IDLE or DONE is ignored; DONE still completes normally.
  - abort takes priority over key_ready.
- When undefined: neither port exists and behaviour is as above.

Test Plan:
- Reset then idle: hold reset 3 cycles, then release with start = 0 for 20 cycles -> all outputs at reset values, busy = 0, and key_word_idx = 0 throughout.
- Nominal NR = 10 with key_ready = 1: pulse start -> 44 xor_en pulses with col_sel sequence 0,1,2,3 repeated; key_word_idx = 0..43; 11 state_wb pulses; mix_bypass high only in round 10; a single done in cycle 100.
- Key stall: key_ready low for 5 cycles on word 17 (round 4, col 1) -> key_req held with key_word_idx = 17; no xor_en until key_ready rises; done arrives 5 cycles late, in cycle 105.
- start while busy: pulse start in cycle 30 of an active block -> ignored; exactly one done; round unchanged by the pulse.
- Reset mid-operation: assert reset in round 6 XOR -> next cycle all outputs at reset values; no done; a new start then runs a full clean 100-cycle block.
- With AES_ROUND_CTRL_ABORT_EN defined: abort in round 3 WB -> no state_wb that cycle; aborted = 1 one cycle later; round = 0; busy = 0; no done.
